stream_bcast: RTL and testbench

STREAM_BCAST -- requirements
Module: stream_bcast

---
 rtl/stream_bcast_pkg.sv | 15 +
 rtl/stream_bcast_chan.sv | 81 ++++++++
 rtl/stream_bcast.sv | 64 ++++++
 tb/tb_stream_bcast.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/stream_bcast_pkg.sv
// Shared constants for the stream broadcaster: default widths and the beat counter width.
// Optional per-channel beat counters are enabled with STREAM_BCAST_STATS_EN.
package stream_bcast_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int NUM_IN_DEF = 2;
  localparam int FANOUT_DEF = 2;
  localparam int CNT_W      = 32;

  // Low bit of lane idx in a vector packed as equal-width lanes of width w.
  function automatic int lane_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/stream_bcast_chan.sv
// One input channel: a one-beat buffer whose data is offered to FANOUT outputs,
// each retiring independently. STREAM_BCAST_STATS_EN adds an accepted-beat counter.
module stream_bcast_chan
  import stream_bcast_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FANOUT = FANOUT_DEF
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  input  logic [FANOUT-1:0] mask,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [FANOUT-1:0] out_valid,
  input  logic [FANOUT-1:0] out_ready,
  output logic              buf_valid
`ifdef STREAM_BCAST_STATS_EN
  ,
  output logic [CNT_W-1:0]  beat_cnt
`endif
);

  logic [DATA_W-1:0] data_q, data_d;
  logic [FANOUT-1:0] pend_q, pend_d;
  logic              valid_q, valid_d;
  logic [FANOUT-1:0] pend_left;
  logic              draining;
  logic              accept;

  always_comb begin
    out_valid = pend_q & {FANOUT{valid_q}};
    pend_left = pend_q & ~(out_valid & out_ready);
    draining  = (pend_left == '0);
    in_ready  = ap_start & (~valid_q | draining);
    accept    = in_valid & in_ready;

    data_d  = data_q;
    pend_d  = pend_left;
    valid_d = valid_q & ~draining;
    // A load in the drain cycle replaces the old beat; a zero mask drops it.
    if (accept) begin
      data_d  = in_data;
      pend_d  = mask;
      valid_d = |mask;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      valid_q <= 1'b0;
      pend_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pend_q  <= pend_d;
    end
    data_q <= data_d;
  end

  assign out_data  = data_q;
  assign buf_valid = valid_q;

`ifdef STREAM_BCAST_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (accept) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign beat_cnt = cnt_q;
`endif

endmodule

// File: rtl/stream_bcast.sv
// AXI-stream broadcaster: each of NUM_IN inputs is copied to FANOUT outputs (k = i*FANOUT + j).
// Defining STREAM_BCAST_STATS_EN adds beat_cnt, one 32-bit accepted-beat counter per input.
module stream_bcast
  import stream_bcast_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NUM_IN = NUM_IN_DEF,
  parameter int FANOUT = FANOUT_DEF
) (
  input  logic                              ap_clk,
  input  logic                              ap_rst,
  input  logic                              ap_start,
  output logic                              ap_idle,
  output logic                              ap_done,
  output logic                              ap_ready,
  input  logic [NUM_IN*FANOUT-1:0]          fanout_mask,
  input  logic [NUM_IN*DATA_W-1:0]          Input_V_TDATA,
  input  logic [NUM_IN-1:0]                 Input_V_TVALID,
  output logic [NUM_IN-1:0]                 Input_V_TREADY,
  output logic [NUM_IN*FANOUT*DATA_W-1:0]   Output_V_TDATA,
  output logic [NUM_IN*FANOUT-1:0]          Output_V_TVALID,
  input  logic [NUM_IN*FANOUT-1:0]          Output_V_TREADY
`ifdef STREAM_BCAST_STATS_EN
  ,
  output logic [NUM_IN*CNT_W-1:0]           beat_cnt
`endif
);

  logic [NUM_IN-1:0] buf_valid;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_chan
    logic [DATA_W-1:0] ch_data;

    stream_bcast_chan #(
      .DATA_W (DATA_W),
      .FANOUT (FANOUT)
    ) u_chan (
      .ap_clk    (ap_clk),
      .ap_rst    (ap_rst),
      .ap_start  (ap_start),
      .mask      (fanout_mask[lane_lo(i, FANOUT) +: FANOUT]),
      .in_data   (Input_V_TDATA[lane_lo(i, DATA_W) +: DATA_W]),
      .in_valid  (Input_V_TVALID[i]),
      .in_ready  (Input_V_TREADY[i]),
      .out_data  (ch_data),
      .out_valid (Output_V_TVALID[lane_lo(i, FANOUT) +: FANOUT]),
      .out_ready (Output_V_TREADY[lane_lo(i, FANOUT) +: FANOUT]),
      .buf_valid (buf_valid[i])
`ifdef STREAM_BCAST_STATS_EN
      ,
      .beat_cnt  (beat_cnt[lane_lo(i, CNT_W) +: CNT_W])
`endif
    );

    for (genvar j = 0; j < FANOUT; j++) begin : g_copy
      assign Output_V_TDATA[lane_lo(i * FANOUT + j, DATA_W) +: DATA_W] = ch_data;
    end
  end

  assign ap_idle  = ~|buf_valid;
  assign ap_done  = 1'b0;
  assign ap_ready = 1'b0;

endmodule

// File: tb/tb_stream_bcast.sv
// Directed self-checking bench for stream_bcast with default parameters (2 inputs x 2 copies).
// beat_cnt checks are compiled in when STREAM_BCAST_STATS_EN is defined.
module tb_stream_bcast;

  logic         ap_clk = 1'b0;
  logic         ap_rst;
  logic         ap_start;
  logic         ap_idle, ap_done, ap_ready;
  logic [3:0]   fanout_mask;
  logic [63:0]  in_data;
  logic [1:0]   in_valid;
  logic [1:0]   in_ready;
  logic [127:0] out_data;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
`ifdef STREAM_BCAST_STATS_EN
  logic [63:0]  beat_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int n0, n1, seen;

  always #5 ap_clk = ~ap_clk;

  stream_bcast dut (
    .ap_clk          (ap_clk),
    .ap_rst          (ap_rst),
    .ap_start        (ap_start),
    .ap_idle         (ap_idle),
    .ap_done         (ap_done),
    .ap_ready        (ap_ready),
    .fanout_mask     (fanout_mask),
    .Input_V_TDATA   (in_data),
    .Input_V_TVALID  (in_valid),
    .Input_V_TREADY  (in_ready),
    .Output_V_TDATA  (out_data),
    .Output_V_TVALID (out_valid),
    .Output_V_TREADY (out_ready)
`ifdef STREAM_BCAST_STATS_EN
    ,
    .beat_cnt        (beat_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  initial begin
    ap_rst = 1'b1; ap_start = 1'b1; fanout_mask = 4'b0011;
    in_data = '0; in_valid = 2'b00; out_ready = 4'b1111;

    // reset behaviour
    step(); step();
    chk("rst_in_ready_during", 64'(in_ready), 64'h3);
    chk("rst_out_valid_during", 64'(out_valid), 64'h0);
    ap_rst = 1'b0;
    step();
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h3);
    chk("rst_idle", 64'(ap_idle), 64'h1);
    chk("rst_done_ready", 64'({ap_done, ap_ready}), 64'h0);

    // back-to-back stream on channel 0, both copies always ready
    for (int v = 1; v <= 3; v++) begin
      in_data[31:0] = 32'(v);
      in_valid = 2'b01;
      #1;
      chk("b2b_in_ready", 64'(in_ready[0]), 64'h1);
      step();
      chk("b2b_out_valid", 64'(out_valid[1:0]), 64'h3);
      chk("b2b_out0_data", 64'(out_data[31:0]), 64'(v));
      chk("b2b_out1_data", 64'(out_data[63:32]), 64'(v));
    end
    in_valid = 2'b00;
    step();
    chk("b2b_drained", 64'(out_valid), 64'h0);
    chk("b2b_idle", 64'(ap_idle), 64'h1);

    // slow copy: output 1 becomes ready only after 3 cycles
    out_ready = 4'b1101;
    in_data[31:0] = 32'hAA;
    in_valid = 2'b01;
    step();
    in_valid = 2'b00;
    n0 = 0; n1 = 0;
    for (int c = 0; c < 6; c++) begin
      out_ready[1] = (c >= 3);
      #1;
      chk("slow_in_ready", 64'(in_ready[0]), (c >= 3) ? 64'h1 : 64'h0);
      if (out_valid[0] && out_ready[0]) begin
        n0++;
        chk("slow_out0_data", 64'(out_data[31:0]), 64'hAA);
      end
      if (out_valid[1] && out_ready[1]) begin
        n1++;
        chk("slow_out1_data", 64'(out_data[63:32]), 64'hAA);
      end
      step();
    end
    chk("slow_out0_count", 64'(n0), 64'h1);
    chk("slow_out1_count", 64'(n1), 64'h1);

    // zero mask on channel 1: accepted and dropped
    out_ready = 4'b1111;
    fanout_mask = 4'b0011;
    in_data[63:32] = 32'h55;
    in_valid = 2'b10;
    #1;
    chk("drop_in_ready", 64'(in_ready[1]), 64'h1);
    step();
    in_valid = 2'b00;
    #1;
    chk("drop_out_valid", 64'(out_valid[3:2]), 64'h0);
    chk("drop_idle", 64'(ap_idle), 64'h1);
`ifdef STREAM_BCAST_STATS_EN
    chk("cnt_ch0", 64'(beat_cnt[31:0]), 64'd4);
    chk("cnt_ch1", 64'(beat_cnt[63:32]), 64'd1);
`endif

    // reset while output 1 still owes 0x77
    out_ready = 4'b1101;
    in_data[31:0] = 32'h77;
    in_valid = 2'b01;
    step();
    in_valid = 2'b00;
    step();
    chk("rstmid_pending", 64'(out_valid[1:0]), 64'h2);
    chk("rstmid_data", 64'(out_data[63:32]), 64'h77);
    ap_rst = 1'b1;
    step();
    chk("rstmid_out_valid", 64'(out_valid), 64'h0);
    chk("rstmid_in_ready", 64'(in_ready), 64'h3);
    chk("rstmid_idle", 64'(ap_idle), 64'h1);
`ifdef STREAM_BCAST_STATS_EN
    chk("rstmid_cnt", beat_cnt, 64'h0);
`endif
    ap_rst = 1'b0;
    out_ready = 4'b1111;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (out_valid != 4'b0000) seen++;
      step();
    end
    chk("rstmid_never_emitted", 64'(seen), 64'h0);

    // ap_start low: buffered beat still drains, no new acceptance
    out_ready = 4'b0000;
    in_data[31:0] = 32'h99;
    in_valid = 2'b01;
    step();
    in_valid = 2'b00;
    ap_start = 1'b0;
    #1;
    chk("stop_in_ready", 64'(in_ready), 64'h0);
    chk("stop_out_valid", 64'(out_valid[1:0]), 64'h3);
    out_ready = 4'b1111;
    #1;
    chk("stop_in_ready_draining", 64'(in_ready[0]), 64'h0);
    chk("stop_out_data", 64'(out_data[63:0]), 64'h00000099_00000099);
    step();
    chk("stop_drained", 64'(out_valid), 64'h0);
    chk("stop_idle", 64'(ap_idle), 64'h1);
    chk("stop_in_ready_after", 64'(in_ready), 64'h0);
    ap_start = 1'b1;
    #1;
    chk("start_in_ready", 64'(in_ready), 64'h3);
`ifdef STREAM_BCAST_STATS_EN
    chk("cnt_after_rst", 64'(beat_cnt[31:0]), 64'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
